md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Multi-cycle multiply/divide sequencer with the HI/LO register pair for the five-stage pipeline. It sits beside the E-stage ALU and takes a one-cycle start pulse when a mult/div/mthi/mtlo instruction is in E. It holds the operation for a fixed latency, then commits HI/LO. It drives a stall request that the hazard unit ORs into its D-stage stall whenever an md-class instruction in D must wait for the unit.

## Interface

Parameters:
- MULT_CYCLES, default 5, busy cycles for mult/multu (and madd family); legal range 1..15
- DIV_CYCLES, default 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  E-stage md instruction valid this cycle
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 reserved
- rs_val  input  32  forwarded E-stage rs operand
- rt_val  input  32  forwarded E-stage rt operand
- d_md  input  1  D-stage instruction is md-class (mult/div/madd family/mthi/mtlo/mfhi/mflo)
- busy  output  1  registered; high while a multi-cycle op is in flight
- md_stall  output  1  combinational stall request to the hazard unit
- hi  output  32  architectural HI, registered
- lo  output  32  architectural LO, registered

## Operation

- States: IDLE, RUN. A 4-bit down-counter cnt and 64-bit pending result res are used.
- IDLE, start=1, op in {1,2,3,4,7..10}: latch the op result into res; cnt←LAT−1 (LAT is MULT_CYCLES or DIV_CYCLES); state←RUN; busy←1.
- IDLE, start=1, op=5: hi←rs_val; op=6: lo←rs_val. Each write takes one edge. No busy.
- IDLE, start=1, op 0 or 11..15: no effect.
- RUN: if cnt==0, then {hi,lo}←res, state←IDLE, busy←0; otherwise cnt←cnt−1.
- start during RUN is ignored. The pipeline guarantees this never occurs, and the bench asserts it.
- mult: signed 32×32→64, {hi,lo}=product. multu: same, unsigned.
- div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. 0x80000000/−1 gives lo=0x80000000, hi=0. divu: unsigned.
- Divide by zero: res={hi,lo} unchanged from the values at start. busy is still held for DIV_CYCLES.
- madd/maddu: res={hi,lo}+product, modulo 2^64. msub/msubu: res={hi,lo}−product. {hi,lo} are sampled at start.
- md_stall = d_md & (busy | (start & op in {1,2,3,4,7..10})).
- Reset (rst_n=0, at any time including mid-RUN): state=IDLE, cnt=0, res=0, busy=0, hi=0, lo=0. An in-flight op is discarded.

## Timing

- Start sampled at edge T. busy is high from after T through edge T+LAT. hi/lo hold the new value and busy is low after edge T+LAT.
- An mfhi/mflo in D therefore stalls for exactly LAT+1 cycles behind a mult in E, counting the start cycle.
- mthi/mtlo: hi/lo update at edge T. A back-to-back mfhi reaches E one cycle later and reads the new value; there is no internal bypass.
- hi/lo do not change while busy=1. They change only at commit, at mthi/mtlo, or at reset.
- md_stall has a combinational path from start/op/d_md. busy is the only registered term.

## Configuration

- MDU_MADD_EN defined: ops 7–10 behave as specified above.
- MDU_MADD_EN undefined: ops 7–10 are treated as reserved (no effect, no busy, no stall contribution). The accumulate adder is not synthesised.

## Test plan

- Reset → hi=0, lo=0, busy=0. Then signed mult, rs=0xFFFFFFFF, rt=2, required response:
  - busy high for 5 cycles;
  - after commit, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div with rs=−7 (0xFFFFFFF9) and rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. Divide by zero → hi/lo unchanged. 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- mult start with d_md=1 in the same cycle → md_stall=1 for 6 consecutive cycles, 0 on the 7th. d_md=0 → md_stall=0 throughout.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 → hi/lo update on successive edges with busy=0. With MDU_MADD_EN: madd with rs=3, rt=4 → lo=0x9ABCDEFC, hi=0x12345678.
- rst_n pulsed low in the 3rd cycle of a div → busy=0 and hi=lo=0 immediately. A new mult started afterwards completes normally in 5 cycles.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle mul/div sequencer owning HI/LO; define MDU_MADD_EN to enable madd/maddu/msub/msubu
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [63:0] res_q, res_d, acc, prod, res_new;
  logic busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, q_u, r_u;
  logic sgn, is_mul, is_div, is_acc, go;
  always_comb begin
    sgn = op == 4'd1 || op == 4'd3 || op == 4'd7 || op == 4'd9;
    is_mul = op == 4'd1 || op == 4'd2;
    is_div = op == 4'd3 || op == 4'd4;
`ifdef MDU_MADD_EN
    is_acc = op >= 4'd7 && op <= 4'd10;
`else
    is_acc = 1'b0;
`endif
    acc = {hi_q, lo_q};
    prod = {{32{sgn & rs_val[31]}}, rs_val} * {{32{sgn & rt_val[31]}}, rt_val};
    // signed divide on magnitudes, then restore signs (quotient toward zero, remainder follows dividend)
    a_mag = sgn & rs_val[31] ? -rs_val : rs_val;
    b_mag = sgn & rt_val[31] ? -rt_val : rt_val;
    q_u = a_mag / b_mag;
    r_u = a_mag % b_mag;
    res_new = !is_div ? prod : rt_val == 32'd0 ? acc :
              {sgn & rs_val[31] ? -r_u : r_u, sgn & (rs_val[31] ^ rt_val[31]) ? -q_u : q_u};
`ifdef MDU_MADD_EN
    if (is_acc) res_new = op >= 4'd9 ? acc - prod : acc + prod;
`endif
    go = start && state_q == IDLE && (is_mul || is_div || is_acc);
    md_stall = d_md & (busy_q | (start & (is_mul | is_div | is_acc)));
    state_d = state_q;
    cnt_d = cnt_q;
    res_d = res_q;
    busy_d = busy_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE) begin
      if (go) begin
        res_d = res_new;
        cnt_d = is_div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
        state_d = RUN;
        busy_d = 1'b1;
      end else if (start && op == 4'd5) begin
        hi_d = rs_val;
      end else if (start && op == 4'd6) begin
        lo_d = rs_val;
      end
    end else if (cnt_q == 4'd0) begin
      {hi_d, lo_d} = res_q;
      state_d = IDLE;
      busy_d = 1'b0;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      res_q <= 64'd0;
      busy_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      busy_q <= busy_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = busy_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: vector table, reset corner cases and randomized ops against an arithmetic model
module tb_md_unit_ctrl;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, d_md = 1'b0;
  logic [3:0] op = 4'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic busy, md_stall;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_bad = 0;

  md_unit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .d_md(d_md), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) assert (!(rst_n && start && busy)) else $error("start issued while busy");

  typedef struct {
    logic [3:0] op;
    logic [31:0] rs, rt;
    logic dm;
    logic [31:0] hi, lo;
    int nb, ns;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] o, input logic [31:0] a, b, input logic dm,
                     input logic [31:0] eh, el, input int nb, ns);
    vec_t v;
    v.op = o; v.rs = a; v.rt = b; v.dm = dm; v.hi = eh; v.lo = el; v.nb = nb; v.ns = ns;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // called at posedge+1; issues one start pulse, then follows busy to completion
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, b, input logic dm,
                       output int nbusy, output int nstall, output bit stable);
    logic [31:0] h0, l0;
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_md = dm;
    #1;
    nstall = int'(md_stall);
    nbusy = 0;
    stable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    h0 = hi; l0 = lo;
    for (int i = 0; i < 20 && busy; i++) begin
      nbusy++;
      nstall += int'(md_stall);
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_check(input string tag, input logic [3:0] o, input logic [31:0] a, b,
                           input logic dm, input logic [31:0] eh, el, input int nb, ns);
    int gb, gs;
    bit st;
    do_op(o, a, b, dm, gb, gs, st);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    chk({tag, "_busy_cycles"}, 64'(gb), 64'(nb));
    chk({tag, "_stall_cycles"}, 64'(gs), 64'(ns));
    chk({tag, "_stall_after"}, {63'd0, md_stall}, 64'd0);
    chk({tag, "_hilo_stable"}, {63'd0, st}, 64'd1);
    d_md = 1'b0;
  endtask

  logic [31:0] mhi, mlo;

  function automatic int lat_of(input logic [3:0] o);
    if (o == 4'd1 || o == 4'd2 || (MADD && o >= 4'd7 && o <= 4'd10)) return 5;
    if (o == 4'd3 || o == 4'd4) return 10;
    return 0;
  endfunction

  task automatic model(input logic [3:0] o, input logic [31:0] a, b);
    longint p;
    int sa, sb;
    logic [63:0] hl;
    sa = a; sb = b;
    hl = {mhi, mlo};
    p = (o == 4'd1 || o == 4'd7 || o == 4'd9) ? longint'(sa) * longint'(sb)
                                               : longint'({32'd0, a}) * longint'({32'd0, b});
    case (o)
      4'd1, 4'd2: hl = p;
      4'd3: if (b != 0) hl = (a == 32'h80000000 && b == 32'hFFFFFFFF) ? {32'd0, a} : {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b != 0) hl = {a % b, a / b};
      4'd5: hl[63:32] = a;
      4'd6: hl[31:0] = a;
      4'd7, 4'd8: if (MADD) hl = hl + p;
      4'd9, 4'd10: if (MADD) hl = hl - p;
      default: ;
    endcase
    {mhi, mlo} = hl;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {63'd0, md_stall}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    add(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 6);
    add(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h00000001, 32'hFFFFFFFE, 5, 0);
    add(4'd1, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 5, 0);
    add(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 5, 6);
    add(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 11);
    add(4'd3, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 11);
    add(4'd4, 32'd7, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    add(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 10, 0);
    add(4'd4, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h00000001, 32'h7FFFFFFF, 10, 0);
    add(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10, 0);
    add(4'd5, 32'h12345678, 32'd0, 1'b1, 32'h12345678, 32'hFFFFFFFD, 0, 0);
    add(4'd6, 32'h9ABCDEF0, 32'd0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    add(4'd0, 32'hDEADBEEF, 32'd1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    add(4'd15, 32'hDEADBEEF, 32'd1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    add(4'd11, 32'hDEADBEEF, 32'd1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    add(4'd7, 32'd3, 32'd4, 1'b1, 32'h12345678, MADD ? 32'h9ABCDEFC : 32'h9ABCDEF0, MADD ? 5 : 0, MADD ? 6 : 0);
    add(4'd10, 32'd3, 32'd4, 1'b0, 32'h12345678, 32'h9ABCDEF0, MADD ? 5 : 0, 0);
    add(4'd9, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h12345678, MADD ? 32'h9ABCDEF1 : 32'h9ABCDEF0, MADD ? 5 : 0, MADD ? 6 : 0);
    add(4'd8, 32'hFFFFFFFF, 32'd1, 1'b0, MADD ? 32'h12345679 : 32'h12345678, 32'h9ABCDEF0, MADD ? 5 : 0, 0);
    foreach (tbl[i])
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].dm,
                tbl[i].hi, tbl[i].lo, tbl[i].nb, tbl[i].ns);

    // asynchronous reset in the third cycle of a divide
    start = 1'b1; op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    repeat (2) begin @(posedge clk); #1; end
    chk("middiv_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("middiv_busy", {63'd0, busy}, 64'd0);
    chk("middiv_hi", {32'd0, hi}, 64'd0);
    chk("middiv_lo", {32'd0, lo}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("post_reset_mult", 4'd1, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 5, 6);

    mhi = 32'd0; mlo = 32'd42;
    for (int k = 0; k < 60; k++) begin
      logic [3:0] o;
      logic [31:0] a, b;
      logic dm;
      int nl;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      dm = 1'($urandom_range(0, 1));
      nl = lat_of(o);
      model(o, a, b);
      run_check($sformatf("rnd%0d_op%0d", k, o), o, a, b, dm, mhi, mlo, nl,
                (dm && nl > 0) ? nl + 1 : 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
